dct8x8_quant_zigzag: RTL and testbench
======================================

// Module: dct8x8_quant_zigzag
// PURPOSE
//   Stage directly downstream of dct8x8_chen_2d. Accepts one 8x8 block of DCT coefficients
//   in parallel (64 words, valid/ready). Quantises each coefficient by a programmable
//   reciprocal table. Streams 64 quantised coefficients out serially, in JPEG zigzag order,
//   to the entropy coder.
// PARAMETERS
//   IN_W    32  width of each input coefficient (signed, two's complement)
//   FRAC     8  fractional bits of input coefficient
//   RCP_W   16  reciprocal table entry width, unsigned Q0.RCP_W
//   OUT_W   12  width of each quantised output coefficient (signed)
// PORTS
//   clk        in   1         clock; all logic on rising edge
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         input block valid
//   in_ready   out  1         stage can accept a block
//   in_data    in   64*IN_W   coefficients, row-major: word r*8+c at [(r*8+c)*IN_W +: IN_W]
//   q_wr_en    in   1         reciprocal table write strobe
//   q_wr_addr  in   6         table index, row-major r*8+c
//   q_wr_data  in   RCP_W     reciprocal 1/Q, unsigned Q0.RCP_W
//   out_valid  out  1         output coefficient valid
//   out_ready  in   1         downstream accepts coefficient
//   out_data   out  OUT_W     quantised coefficient
//   out_idx    out  6         zigzag position 0..63 of out_data
//   out_last   out  1         high with out_idx==63
// BEHAVIOUR
// - Reset values: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0.
//   FSM returns to IDLE. All 64 table entries = 16'h1000 (1/16). Block buffer is cleared.
// - FSM IDLE: in_ready=1.
//   - in_valid&&in_ready on an edge latches all 64 words into the block buffer.
//   - On that same edge: go to RUN, drop in_ready, and set zigzag counter k=0.
// - FSM RUN: in_ready=0. Output register loads when !out_valid || out_ready.
//   - Load value: coefficient at row-major position ZZ[k]. out_idx=k, out_last=(k==63).
//   - After each load, k increments.
//   - First out_valid is asserted one cycle after the accept edge.
//   - With out_ready held high, exactly one word moves per cycle, 64 cycles per block.
// - Leaving RUN:
//   - The handshake of the word with k==63 returns the FSM to IDLE.
//   - in_ready=1 from the next cycle. No overlap of blocks.
//   - out_valid drops unless a new word is loaded.
// - Backpressure: while out_valid && !out_ready, out_data/out_idx/out_last hold stable.
// - ZZ order is standard JPEG: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,...,62,63.
//   It is held in a 64-entry constant table.
// - Arithmetic, for p = coef * {1'b0, recip}:
//   - Use a signed product of at least IN_W+RCP_W+1 bits.
//   - Scale S = FRAC+RCP_W.
//   - Round half away from zero: p>=0 -> (p + 2^(S-1)) >>> S, p<0 -> -((-p + 2^(S-1)) >>> S).
//   - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
// - Table writes:
//   - Honoured only in IDLE, including the accept cycle itself.
//   - q_wr_en in RUN is ignored, so one block is always quantised with one table.
// - Reset asserted mid-block aborts the block. No further outputs; state is as at reset.
// CONFIGURATION
//   DCTQ_DC_DPCM_EN defined:
//   - The word with out_idx==0 carries q_DC - pred, saturated to OUT_W.
//   - pred <= q_DC (unsaturated quantised DC, clipped to OUT_W) when that word handshakes.
//   - pred resets to 0 on rst_n.
//   DCTQ_DC_DPCM_EN undefined: DC is output as-is. No pred register.
// TESTING
//   1 All-zero block, default table -> 64 words of 0, out_idx 0..63, out_last only on idx 63.
//   2 DC=800.0 (0x00032000), rest 0, default table -> out_data[idx0]=50, others 0.
//     With DPCM_EN, a second identical block gives DC word 0.
//   3 Zigzag order:
//     - Stimulus: word i = 2*i<<8, all table entries 0x8000 (1/2).
//     - Response: out sequence 0,1,8,16,9,2,3,10,17,24,... matches ZZ.
//   4 Rounding/saturation, table 0x1000:
//     - +24.0 -> 2, -24.0 -> -2, +8.0 -> 1 (0.5 rounds away).
//     - -100000.0 -> -2048, +100000.0 -> 2047.
//   5 Backpressure:
//     - Stimulus: out_ready low 5 cycles at idx 10; q_wr_en pulses during RUN.
//     - Response: idx10 word stable; table unchanged; 64 words total.
//   6 Reset at idx 30 -> out_valid=0, in_ready=1 next cycle. Next block streams from idx 0 correctly.

Source files
------------

// File: rtl/dct8x8_quant_zigzag.sv
`default_nettype none
// =============================================================================
// dct8x8_quant_zigzag : 8x8 DCT block quantiser with JPEG zigzag serial output.
// Optional DC DPCM when DCTQ_DC_DPCM_EN is defined.        Revision: 1.0
// =============================================================================
module dct8x8_quant_zigzag #(
  parameter int IN_W  = 32,
  parameter int FRAC  = 8,
  parameter int RCP_W = 16,
  parameter int OUT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [64*IN_W-1:0]   in_data,
  input  logic                 q_wr_en,
  input  logic [5:0]           q_wr_addr,
  input  logic [RCP_W-1:0]     q_wr_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [5:0]           out_idx,
  output logic                 out_last
);

  // Product gets two spare bits so negating the most negative product cannot wrap.
  localparam int P_W = IN_W + RCP_W + 2;
  localparam int S   = FRAC + RCP_W;
  localparam logic signed [P_W-1:0] HALF = P_W'(1) << (S - 1);
  localparam logic signed [P_W-1:0] QMAX = P_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [P_W-1:0] QMIN = -QMAX - P_W'(1);

  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                   state, state_nx;
  logic signed [IN_W-1:0]   blk [64];
  logic [RCP_W-1:0]         rcp [64];
  logic [6:0]               k;
  logic [5:0]               pos;
  logic signed [P_W-1:0]    coef_x, rcp_x, prod, mag, mag_r, q_full;
  logic signed [OUT_W-1:0]  q_sat, word;
  logic                     accept, load, hs;

  function automatic logic [OUT_W-1:0] clip(input logic signed [P_W-1:0] v);
    if (v > QMAX) return QMAX[OUT_W-1:0];
    if (v < QMIN) return QMIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

`ifdef DCTQ_DC_DPCM_EN
  logic signed [OUT_W-1:0]  dc_q, pred;
`endif

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: if (out_valid && out_ready && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && in_valid;
  assign hs     = out_valid && out_ready;
  // k[6] marks that all 64 words have been loaded; only the last handshake remains.
  assign load   = (state == RUN) && !k[6] && (!out_valid || out_ready);

  always_comb begin
    pos    = 6'(ZZ[k[5:0]]);
    coef_x = P_W'(blk[pos]);
    rcp_x  = P_W'(rcp[pos]);
    prod   = coef_x * rcp_x;
    mag    = prod[P_W-1] ? -prod : prod;
    mag_r  = (mag + HALF) >>> S;
    q_full = prod[P_W-1] ? -mag_r : mag_r;
    q_sat  = clip(q_full);
    word   = q_sat;
`ifdef DCTQ_DC_DPCM_EN
    if (k[5:0] == 6'd0) word = clip(P_W'(q_sat) - P_W'(pred));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        blk[i] <= '0;
        rcp[i] <= RCP_W'(16'h1000);
      end
    end else if (state == IDLE) begin
      if (q_wr_en) rcp[q_wr_addr] <= q_wr_data;
      if (in_valid)
        for (int i = 0; i < 64; i++) blk[i] <= in_data[i*IN_W +: IN_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      k         <= '0;
    end else if (accept) begin
      k <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= word;
      out_idx   <= k[5:0];
      out_last  <= (k[5:0] == 6'd63);
      k         <= k + 7'd1;
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DCTQ_DC_DPCM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_q <= '0;
      pred <= '0;
    end else begin
      if (load && k[5:0] == 6'd0) dc_q <= q_sat;
      if ((state == RUN) && hs && out_idx == 6'd0) pred <= dc_q;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dct8x8_quant_zigzag.sv
`default_nettype none
// Bench for dct8x8_quant_zigzag: scoreboard of expected zigzag words, one task per scenario.
module tb_dct8x8_quant_zigzag;
  localparam int IN_W = 32, FRAC = 8, RCP_W = 16, OUT_W = 12;

  logic                clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, q_wr_en = 1'b0, out_ready = 1'b1;
  logic                in_ready, out_valid, out_last;
  logic [64*IN_W-1:0]  in_data = '0;
  logic [5:0]          q_wr_addr = '0, out_idx;
  logic [RCP_W-1:0]    q_wr_data = '0;
  logic [OUT_W-1:0]    out_data;

  always #5 clk = ~clk;

  dct8x8_quant_zigzag #(.IN_W(IN_W), .FRAC(FRAC), .RCP_W(RCP_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .q_wr_en(q_wr_en), .q_wr_addr(q_wr_addr), .q_wr_data(q_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last));

  typedef struct packed { logic [OUT_W-1:0] data; logic [5:0] idx; logic last; } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  int              errors = 0, checks = 0;
  int              zz[64], tbl[64], blk[64];
  int              pred = 0;
  logic [OUT_W-1:0] seen[64];

  function automatic int sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Reference quantiser in floating point; all intermediate values are exact in a double.
  function automatic int quant(input int coef, input int r);
    real x, ax;
    int  q;
    x  = (real'(coef) * real'(r)) / 16777216.0;
    ax = (x < 0.0) ? -x : x;
    q  = $rtoi(ax + 0.5);
    if (x < 0.0) q = -q;
    return sat(q);
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got idx=%0d data=%0d, want no word", out_idx, $signed(out_data));
      end else begin
        mon_e = sb.pop_front();
        if ({out_data, out_idx, out_last} !== mon_e) begin
          errors++;
          $display("FAIL word: got data=%0d idx=%0d last=%b, want data=%0d idx=%0d last=%b",
                   $signed(out_data), out_idx, out_last, $signed(mon_e.data), mon_e.idx, mon_e.last);
        end
      end
      seen[out_idx] = out_data;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic write_tbl(input int addr, input int data);
    q_wr_en = 1'b1; q_wr_addr = 6'(addr); q_wr_data = RCP_W'(data);
    @(posedge clk); #1;
    q_wr_en = 1'b0;
    tbl[addr] = data;
  endtask

  // Pushes expectations, presents the block and returns 1 time unit after the accept edge.
  task automatic send_block();
    exp_t e;
    int   q, d, n;
    for (int i = 0; i < 64; i++) begin
      q = quant(blk[zz[i]], tbl[zz[i]]);
`ifdef DCTQ_DC_DPCM_EN
      if (i == 0) begin d = sat(q - pred); pred = q; q = d; end
`endif
      e.data = OUT_W'(q); e.idx = 6'(i); e.last = (i == 63);
      sb.push_back(e);
    end
    for (int i = 0; i < 64; i++) in_data[i*IN_W +: IN_W] = blk[i];
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready=%b, want 1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit rand_ready);
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 3000) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d in_ready=%b, want 0 and 1", sb.size(), in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_idx, out_last} !== {1'b1, 1'b0, 12'd0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%0d idx=%0d last=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_data, out_idx, out_last);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_zero_block();
    for (int i = 0; i < 64; i++) blk[i] = 0;
    send_block();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_edge: got vld=%b rdy=%b, want 0 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 6'd0) begin
      errors++;
      $display("FAIL first_word: got vld=%b idx=%0d, want 1 0", out_valid, out_idx);
    end
    wait_drain(1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_after_block: got %b, want 0", out_valid);
    end
  endtask

  task automatic test_dc();
    int want2;
    for (int i = 0; i < 64; i++) blk[i] = 0;
    blk[0] = 32'h0003_2000;
    send_block();
    wait_drain(1'b0);
    checks++;
    if ($signed(seen[0]) !== 12'sd50 || seen[1] !== 12'd0) begin
      errors++;
      $display("FAIL dc_800: got dc=%0d ac1=%0d, want 50 0", $signed(seen[0]), $signed(seen[1]));
    end
    send_block();
    wait_drain(1'b0);
`ifdef DCTQ_DC_DPCM_EN
    want2 = 0;
`else
    want2 = 50;
`endif
    checks++;
    if ($signed(seen[0]) != want2) begin
      errors++;
      $display("FAIL dc_second_block: got %0d, want %0d", $signed(seen[0]), want2);
    end
  endtask

  task automatic test_zigzag();
    int spec_zz[10] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
    for (int i = 0; i < 64; i++) write_tbl(i, 16'h8000);
    for (int i = 0; i < 64; i++) blk[i] = (2 * i) << 8;
    send_block();
    wait_drain(1'b0);
`ifdef DCTQ_DC_DPCM_EN
    for (int n = 1; n < 10; n++) begin
`else
    for (int n = 0; n < 10; n++) begin
`endif
      checks++;
      if (int'(seen[n]) != spec_zz[n]) begin
        errors++;
        $display("FAIL zigzag_pos%0d: got %0d, want %0d", n, seen[n], spec_zz[n]);
      end
    end
    for (int i = 0; i < 64; i++) write_tbl(i, 16'h1000);
  endtask

  task automatic test_rounding();
    int want[6] = '{2, -2, 1, -2048, 2047, -1};
    for (int i = 0; i < 64; i++) blk[i] = 0;
    blk[0] = 24 << 8;  blk[1] = -(24 << 8); blk[8] = 8 << 8;
    blk[16] = -100000 * 256; blk[9] = 100000 * 256; blk[2] = -(8 << 8);
    send_block();
    wait_drain(1'b0);
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (int'($signed(seen[n])) != want[n]) begin
        errors++;
        $display("FAIL round_sat_idx%0d: got %0d, want %0d", n, $signed(seen[n]), want[n]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom) >>> (6 + (i % 6));
    send_block();
    while (!(out_valid && out_idx == 6'd10) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      q_wr_en = 1'b1; q_wr_addr = 6'(c); q_wr_data = 16'h0001;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || {out_data, out_idx, out_last} !== sb[0] || sb[0].idx != 6'd10) begin
        errors++;
        $display("FAIL hold_idx10_cycle%0d: got vld=%b idx=%0d data=%0d, want 1 10 %0d",
                 c, out_valid, out_idx, $signed(out_data), $signed(sb[0].data));
      end
    end
    q_wr_en = 1'b0;
    out_ready = 1'b1;
    wait_drain(1'b0);
    send_block();
    wait_drain(1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom) >>> 9;
    send_block();
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom) >>> 12;
    send_block();
    wait_drain(1'b1);
  endtask

  task automatic test_reset_mid_block();
    int n = 0;
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom) >>> 10;
    send_block();
    while (!(out_valid && out_idx == 6'd30) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    pred = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_block: got vld=%b rdy=%b idx=%0d, want 0 1 0", out_valid, in_ready, out_idx);
    end
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < 64; i++) blk[i] = (i - 32) << 10;
    send_block();
    wait_drain(1'b0);
  endtask

  initial begin
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin zz[n] = r * 8 + (s - r); n++; end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin zz[n] = r * 8 + (s - r); n++; end
      end
    end
    for (int i = 0; i < 64; i++) begin tbl[i] = 16'h1000; seen[i] = '0; end

    test_reset();
    test_zero_block();
    test_dc();
    test_zigzag();
    test_rounding();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_block();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
